// File: rtl/btn_conditioner.sv
// Multi-channel button front end: synchroniser, debounce, edge pulses,
// hold/press counters and auto-repeat. Every output is registered.
module btn_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic                           tick,
  input  logic                           clr,
  input  logic [NUM_BTN-1:0]             repeat_en,
  input  logic [NUM_BTN-1:0]             btn_in,
  output logic [NUM_BTN-1:0]             btn_level,
  output logic [NUM_BTN-1:0]             btn_press,
  output logic [NUM_BTN-1:0]             btn_release,
  output logic [NUM_BTN-1:0]             btn_repeat,
  output logic [NUM_BTN*CNT_WIDTH-1:0]   hold_cnt,
  output logic [NUM_BTN*CNT_WIDTH-1:0]   press_cnt
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RT_W   = $clog2(RT_MAX) + 1;

  localparam logic [DB_W-1:0]      DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RT_W-1:0]      RT_DLY  = RT_W'(REPEAT_DELAY);
  localparam logic [RT_W-1:0]      RT_PER  = RT_W'(REPEAT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, HELD} rpt_state_t;

  logic [NUM_BTN-1:0]   sync_a;
  logic [NUM_BTN-1:0]   sync_s;
  logic [DB_W-1:0]      db      [NUM_BTN];
  logic [RT_W-1:0]      rt      [NUM_BTN];
  rpt_state_t           state   [NUM_BTN];
  logic [CNT_WIDTH-1:0] hold_q  [NUM_BTN];
  logic [CNT_WIDTH-1:0] press_q [NUM_BTN];
  logic [NUM_BTN-1:0]   flip;

  // flip marks the edge on which the debounced level takes the synchronised value.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    flip = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      flip[i] = (sync_s[i] != btn_level[i]) && (db[i] == DB_LAST);
    end
  end

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_a      <= '0;
      sync_s      <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      // NOTE: the per-channel arrays are small register sets, not RAM, so they take reset.
      for (int i = 0; i < NUM_BTN; i++) begin
        db[i]      <= '0;
        rt[i]      <= '0;
        state[i]   <= IDLE;
        hold_q[i]  <= '0;
        press_q[i] <= '0;
      end
    end else begin
      sync_a <= btn_in;
      sync_s <= sync_a;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync_s[i] == btn_level[i]) begin
          db[i] <= '0;
        end else if (flip[i]) begin
          db[i]        <= '0;
          btn_level[i] <= sync_s[i];
        end else begin
          db[i] <= db[i] + 1'b1;
        end

        btn_press[i]   <= flip[i] &&  sync_s[i];
        btn_release[i] <= flip[i] && !sync_s[i];

        if (clr) begin
          press_q[i] <= '0;
        end else if (flip[i] && sync_s[i]) begin
          press_q[i] <= press_q[i] + 1'b1;
        end

        // A tick on the press edge is not counted: btn_level is still low then.
        if (clr || flip[i] || !btn_level[i]) begin
          hold_q[i] <= '0;
        end else if (tick && (hold_q[i] != CNT_MAX)) begin
          hold_q[i] <= hold_q[i] + 1'b1;
        end

        btn_repeat[i] <= 1'b0;
        case (state[i])
          IDLE: begin
            if (flip[i] && sync_s[i]) begin
              state[i]      <= HELD;
              rt[i]         <= RT_DLY;
              btn_repeat[i] <= 1'b1;
            end
          end
          HELD: begin
            // In HELD the level is high, so a flip is a release and beats expiry.
            if (flip[i]) begin
              state[i] <= IDLE;
              rt[i]    <= '0;
            end else if (tick) begin
              if (rt[i] == RT_W'(1)) begin
                btn_repeat[i] <= repeat_en[i];
                rt[i]         <= RT_PER;
              end else begin
                rt[i] <= rt[i] - 1'b1;
              end
            end
          end
          default: begin
            state[i] <= IDLE;
            rt[i]    <= '0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_pack
    assign hold_cnt [g*CNT_WIDTH +: CNT_WIDTH] = hold_q[g];
    assign press_cnt[g*CNT_WIDTH +: CNT_WIDTH] = press_q[g];
  end

endmodule
